// File: rtl/axi_rd_arbiter.sv
// N-port read arbiter funnelling request/response clients onto one AXI4 read master.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axi_rd_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_LEN   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*8-1:0]    req_len,
  input  logic [NUM_PORTS*3-1:0]    req_size,
  output logic [NUM_PORTS-1:0]      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [ID_W-1:0]           ARID,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [ID_W-1:0]           RID,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_LEN) + 1;
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [CW-1:0]       cnt_q, cnt_d;
`ifndef AXI_ARB_FIXED_PRIO_EN
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       scan_idx;
`endif

  logic                gnt_any;
  logic [PW-1:0]       gnt_idx;
  logic [7:0]          sel_len;
  logic                at_end;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_valid[PW'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
`else
    scan_idx = '0;
    // Scan from the pointer upwards, wrapping, so the last winner goes to the back.
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = PW'((int'(rr_q) + k) % NUM_PORTS);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
`ifndef AXI_ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif
    req_ready = '0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    sel_len   = req_len[int'(gnt_idx)*8 +: 8];
    at_end    = (9'(cnt_q) == {1'b0, len_q});
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = ~rst;
          grant_d = gnt_idx;
          addr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          size_d  = req_size[int'(gnt_idx)*3 +: 3];
          len_d   = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          rsp_valid[grant_q] = 1'b1;
          rsp_data = RDATA;
          // A missing RLAST on the expected final beat still closes the burst.
          rsp_last = RLAST | at_end;
          rsp_err  = (RRESP != 2'b00) | (RID != ID_W'(grant_q)) |
                     (RLAST & ~at_end) | (at_end & ~RLAST);
          cnt_d    = cnt_q + 1'b1;
          if (RLAST || at_end) begin
            state_d = S_IDLE;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign ARID    = ID_W'(grant_q);
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = 2'b01;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter with a hand-driven AXI slave.
module tb_axi_rd_arbiter;
  localparam int N = 2, AW = 64, DW = 64, IW = 4, ML = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0] req_len;
  logic [N*3-1:0] req_size;
  logic [DW-1:0] rsp_data, RDATA;
  logic rsp_last, rsp_err;
  logic [IW-1:0] ARID, RID;
  logic [AW-1:0] ARADDR;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE;
  logic [1:0] ARBURST, RRESP;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_pass = 0;
  int n_tot = 0;

  axi_rd_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Issues one request on port p and completes the AR handshake; returns the req_ready seen at grant.
  task automatic start_txn(input int p, input logic [AW-1:0] a, input logic [7:0] l,
                           output logic [N-1:0] seen);
    req_addr[p*AW +: AW] = a;
    req_len[p*8 +: 8] = l;
    req_size[p*3 +: 3] = 3'd3;
    req_valid = N'(1) << p;
    smp;
    seen = req_ready;
    cyc;
    req_valid = '0;
    ARREADY = 1'b1;
    smp;
    cyc;
    ARREADY = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_tot++;
    if ({ARVALID, RREADY, req_ready, rsp_valid, rsp_last, rsp_err} !== '0)
      $display("FAIL reset_ctrl got %b want 0", {ARVALID, RREADY, req_ready, rsp_valid, rsp_last, rsp_err});
    else n_pass++;
    n_tot++;
    if ({ARADDR, ARLEN, ARSIZE, ARID, ARBURST} !== {{(AW+8+3+IW){1'b0}}, 2'b01})
      $display("FAIL reset_ar got %h/%h/%h/%h/%b want 0/0/0/0/01", ARADDR, ARLEN, ARSIZE, ARID, ARBURST);
    else n_pass++;
    smp;
    rst = 1'b0;
    cyc;
  endtask

  task automatic test_single;
    req_addr[0 +: AW] = 64'h8000_0000;
    req_len[7:0] = 8'd0;
    req_size[2:0] = 3'd3;
    req_valid = 2'b01;
    ARREADY = 1'b1;
    smp;
    n_tot++;
    if ({req_ready, ARVALID} !== 3'b010)
      $display("FAIL single_c0 got %b want 010", {req_ready, ARVALID});
    else n_pass++;
    cyc;
    req_valid = '0;
    smp;
    n_tot++;
    if ({ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARADDR} !== {1'b1, 4'd0, 8'd0, 3'd3, 2'b01, 64'h8000_0000})
      $display("FAIL single_ar got v%b id%h len%h sz%h b%b a%h", ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARADDR);
    else n_pass++;
    cyc;
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 64'h13; RLAST = 1'b1; RRESP = 2'b00; RID = 4'd0;
    smp;
    n_tot++;
    if ({RREADY, rsp_valid, rsp_last, rsp_err, rsp_data} !== {1'b1, 2'b01, 1'b1, 1'b0, 64'h13})
      $display("FAIL single_rsp got r%b v%b l%b e%b d%h", RREADY, rsp_valid, rsp_last, rsp_err, rsp_data);
    else n_pass++;
    cyc;
    RVALID = 1'b0; RLAST = 1'b0;
    smp;
    n_tot++;
    if ({ARVALID, RREADY, rsp_valid} !== 4'b0)
      $display("FAIL single_idle got %b want 0000", {ARVALID, RREADY, rsp_valid});
    else n_pass++;
    cyc;
  endtask

  task automatic test_round_robin;
    logic [0:0] e;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    req_addr = {64'h2000, 64'h1000};
    req_len = '0;
    req_valid = 2'b11;
    ARREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      e = 1'b0;
`else
      e = 1'(t % 2);
`endif
      smp;
      n_tot++;
      if (req_ready !== (2'b01 << e))
        $display("FAIL rr_grant%0d got %b want %b", t, req_ready, 2'b01 << e);
      else n_pass++;
      cyc;
      smp;
      n_tot++;
      if ({ARVALID, ARID, ARADDR} !== {1'b1, IW'(e), (e ? 64'h2000 : 64'h1000)})
        $display("FAIL rr_ar%0d got v%b id%h a%h want id%h", t, ARVALID, ARID, ARADDR, e);
      else n_pass++;
      cyc;
      RVALID = 1'b1; RID = IW'(e); RLAST = 1'b1; RRESP = 2'b00; RDATA = 64'h100 + 64'(t);
      smp;
      n_tot++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b01 << e, 1'b0, 64'h100 + 64'(t)})
        $display("FAIL rr_rsp%0d got v%b e%b d%h", t, rsp_valid, rsp_err, rsp_data);
      else n_pass++;
      cyc;
      RVALID = 1'b0; RLAST = 1'b0;
    end
    req_valid = '0;
    ARREADY = 1'b0;
    cyc;
  endtask

  task automatic test_burst_stall;
    req_addr[AW +: AW] = 64'h1000_0040;
    req_len[15:8] = 8'd3;
    req_size[5:3] = 3'd3;
    req_valid = 2'b10;
    ARREADY = 1'b0;
    smp;
    n_tot++;
    if (req_ready !== 2'b10) $display("FAIL burst_grant got %b want 10", req_ready);
    else n_pass++;
    cyc;
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) ARREADY = 1'b1;
      smp;
      n_tot++;
      if ({ARVALID, ARID, ARLEN, ARADDR} !== {1'b1, 4'd1, 8'd3, 64'h1000_0040})
        $display("FAIL burst_ar_hold%0d got v%b id%h len%h a%h", c, ARVALID, ARID, ARLEN, ARADDR);
      else n_pass++;
      cyc;
    end
    ARREADY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      RVALID = 1'b1; RID = 4'd1; RRESP = 2'b00; RDATA = 64'hD0 + 64'(b); RLAST = (b == 3);
      smp;
      n_tot++;
      if ({rsp_valid, rsp_last, rsp_err, rsp_data} !== {2'b10, (b == 3), 1'b0, 64'hD0 + 64'(b)})
        $display("FAIL burst_beat%0d got v%b l%b e%b d%h", b, rsp_valid, rsp_last, rsp_err, rsp_data);
      else n_pass++;
      cyc;
      if (b == 1) begin
        RVALID = 1'b0;
        smp;
        n_tot++;
        if ({RREADY, rsp_valid} !== 3'b100)
          $display("FAIL burst_gap got %b want 100", {RREADY, rsp_valid});
        else n_pass++;
        cyc;
      end
    end
    RVALID = 1'b0; RLAST = 1'b0;
    smp;
    n_tot++;
    if ({ARVALID, RREADY} !== 2'b00) $display("FAIL burst_done got %b want 00", {ARVALID, RREADY});
    else n_pass++;
    cyc;
  endtask

  task automatic test_resp_err;
    logic [N-1:0] seen;
    logic [1:0] t_resp [3] = '{2'b10, 2'b00, 2'b00};
    logic [3:0] t_id [3] = '{4'd0, 4'd0, 4'd3};
    logic t_err [3] = '{1'b1, 1'b0, 1'b1};
    start_txn(0, 64'h3000, 8'd2, seen);
    n_tot++;
    if (seen !== 2'b01) $display("FAIL err_grant got %b want 01", seen);
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      RVALID = 1'b1; RRESP = t_resp[b]; RID = t_id[b]; RLAST = (b == 2); RDATA = 64'(b);
      smp;
      n_tot++;
      if ({rsp_valid, rsp_last, rsp_err} !== {2'b01, (b == 2), t_err[b]})
        $display("FAIL err_beat%0d got v%b l%b e%b want e%b", b, rsp_valid, rsp_last, rsp_err, t_err[b]);
      else n_pass++;
      cyc;
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = 4'd0;
    smp;
    n_tot++;
    if (RREADY !== 1'b0) $display("FAIL err_done got RREADY=%b want 0", RREADY);
    else n_pass++;
    cyc;
  endtask

  task automatic test_len_violation;
    logic [N-1:0] seen;
    start_txn(0, 64'h4000, 8'd3, seen);
    for (int b = 0; b < 3; b++) begin
      RVALID = 1'b1; RID = 4'd0; RRESP = 2'b00; RLAST = (b == 2);
      smp;
      n_tot++;
      if ({rsp_valid, rsp_last, rsp_err} !== {2'b01, (b == 2), (b == 2)})
        $display("FAIL early_last%0d got v%b l%b e%b", b, rsp_valid, rsp_last, rsp_err);
      else n_pass++;
      cyc;
    end
    RVALID = 1'b0; RLAST = 1'b0;
    smp;
    n_tot++;
    if (RREADY !== 1'b0) $display("FAIL early_idle got RREADY=%b want 0", RREADY);
    else n_pass++;
    cyc;
    start_txn(0, 64'h4100, 8'd1, seen);
    for (int b = 0; b < 2; b++) begin
      RVALID = 1'b1; RID = 4'd0; RRESP = 2'b00; RLAST = 1'b0;
      smp;
      n_tot++;
      if ({rsp_valid, rsp_last, rsp_err} !== {2'b01, (b == 1), (b == 1)})
        $display("FAIL miss_last%0d got v%b l%b e%b", b, rsp_valid, rsp_last, rsp_err);
      else n_pass++;
      cyc;
    end
    RVALID = 1'b0;
    smp;
    n_tot++;
    if ({RREADY, rsp_valid} !== 3'b000) $display("FAIL miss_idle got %b want 000", {RREADY, rsp_valid});
    else n_pass++;
    cyc;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] seen;
    start_txn(1, 64'h5000, 8'd3, seen);
    n_tot++;
    if (seen !== 2'b10) $display("FAIL rstmid_grant got %b want 10", seen);
    else n_pass++;
    for (int b = 0; b < 2; b++) begin
      RVALID = 1'b1; RID = 4'd1; RRESP = 2'b00; RLAST = 1'b0; RDATA = 64'hE0 + 64'(b);
      cyc;
    end
    RDATA = 64'hE2;
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    n_tot++;
    if ({ARVALID, RREADY, req_ready, rsp_valid, rsp_last, rsp_err, rsp_data} !== '0)
      $display("FAIL rstmid_outs got %b d%h want 0", {ARVALID, RREADY, req_ready, rsp_valid, rsp_last, rsp_err}, rsp_data);
    else n_pass++;
    smp;
    rst = 1'b0;
    RVALID = 1'b0;
    #1;
    n_tot++;
    if (req_ready !== 2'b01) $display("FAIL rstmid_regrant got %b want 01", req_ready);
    else n_pass++;
    cyc;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    #3;
    test_reset;
    test_single;
    test_round_robin;
    test_burst_stall;
    test_resp_err;
    test_len_violation;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
